ndma_read_mgr: RTL

Read-side OBI manager of the NanoDMA datapath, the counterpart of the write manager. Accepts word-read requests from the DMA core and issues them as OBI read transactions, with up to BUF_DEPTH transactions in flight. Buffers returned read data in a FIFO and presents it to the core over a valid/ready handshake. Read-data space is reserved by credits, so OBI `rready` is held high permanently.

---
 rtl/ndma_read_mgr_if.sv | 28 ++
 rtl/ndma_read_mgr.sv | 118 +++++++++++
 2 files changed

// File: rtl/ndma_read_mgr_if.sv
// OBI bus bundle shared by the NanoDMA read/write managers and their subordinates.
// Manager drives the address phase and rready; subordinate drives gnt and the response.
interface OBI_BUS;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
    logic        a_optional;
    logic        reqpar;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        err;
    logic        rreadypar;

    modport Manager (
        output req, addr, we, be, wdata, aid, a_optional, reqpar, rready, rreadypar,
        input  gnt, rvalid, rdata, err
    );

    modport Subordinate (
        input  req, addr, we, be, wdata, aid, a_optional, reqpar, rready, rreadypar,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ndma_read_mgr.sv
// NanoDMA read-side OBI manager: credit-limited read issue with an in-order response FIFO.
// Credits cover pending address phase, outstanding reads and buffered data, so rready stays high.
module ndma_read_mgr #(
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        req_ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        rerr_o,
    input  logic        rready_i,
    output logic        busy_o,
    OBI_BUS.Manager     read_mgr
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    // state  | meaning
    // S_IDLE | no address phase pending
    // S_REQ  | address phase on the bus, waiting for gnt
    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   credits_q, credits_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [32:0]     mem_q [BUF_DEPTH];

    logic accept, push, pop, empty, full;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(BUF_DEPTH));
    assign push        = read_mgr.rvalid;
    assign pop         = !empty && rready_i;
    assign req_ready_o = (credits_q < CW'(BUF_DEPTH)) &&
                         ((state_q == S_IDLE) || read_mgr.gnt);
    assign accept      = req_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (read_mgr.gnt && !accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        read_mgr.req  = (state_q == S_REQ);
        read_mgr.addr = addr_q;
    end

    assign read_mgr.we         = 1'b0;
    assign read_mgr.be         = 4'hF;
    assign read_mgr.wdata      = '0;
    assign read_mgr.aid        = 1'b0;
    assign read_mgr.a_optional = 1'b0;
    assign read_mgr.reqpar     = 1'b0;
    assign read_mgr.rready     = 1'b1;
    assign read_mgr.rreadypar  = 1'b0;

    always_comb begin
        addr_d    = accept ? {addr_i[31:2], 2'b00} : addr_q;
        credits_d = credits_q;
        if (accept && !pop) credits_d = credits_q + CW'(1);
        else if (!accept && pop) credits_d = credits_q - CW'(1);
        count_d = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
        wptr_d = wptr_q;
        if (push) wptr_d = (wptr_q == PW'(BUF_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        rptr_d = rptr_q;
        if (pop) rptr_d = (rptr_q == PW'(BUF_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q    <= '0;
            credits_q <= '0;
            count_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
        end else begin
            addr_q    <= addr_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {read_mgr.err, read_mgr.rdata};
    end

    assign rvalid_o = !empty;
    assign rdata_o  = empty ? 32'h0 : mem_q[rptr_q][31:0];
    assign rerr_o   = empty ? 1'b0  : mem_q[rptr_q][32];
    assign busy_o   = (credits_q != '0);

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule
